imem_bridge: RTL and testbench

Memory-side counterpart of the RS5 fetch stage: accepts the fetch unit's per-cycle address/tag stream, issues it as in-order requests on a pipelined instruction-memory bus, and returns each instruction to decode with its tag. Credit-based flow control bounds the number of requests in flight. Responses whose tag no longer matches decode's current tag (wrong path after a jump, trap or mret) are dropped silently.

---
 rtl/imem_bridge_pkg.sv | 13 +
 rtl/imem_fifo.sv | 60 ++++++
 rtl/imem_bridge.sv | 99 +++++++++
 tb/tb_imem_bridge.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_bridge_pkg.sv
// Shared types for the instruction-memory bridge: the response entry that
// carries a fetched word back to decode together with its tag and fault bit.
package imem_bridge_pkg;

  localparam int TAG_W = 3;

  typedef struct packed {
    logic [31:0]      rdata;
    logic [TAG_W-1:0] tag;
    logic             err;
  } resp_entry_t;

endpackage

// File: rtl/imem_fifo.sv
// Small synchronous FIFO with registered storage and a combinational head.
// Used for both the in-flight tag queue and the response queue of the bridge.
module imem_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             doPush, doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + PW'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + PW'(1);
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/imem_bridge.sv
// Bridge between the fetch stage and a pipelined instruction-memory bus.
// Credits bound in-flight requests; stale-tag responses are dropped silently.
module imem_bridge
  import imem_bridge_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_en_i,
  input  logic [31:0]      req_addr_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             req_ready_o,
  output logic             mem_req_o,
  output logic [31:0]      mem_addr_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  input  logic [31:0]      mem_rdata_i,
  input  logic             mem_err_i,
  input  logic [TAG_W-1:0] expected_tag_i,
  input  logic             instr_ready_i,
  output logic             instr_valid_o,
  output logic [31:0]      instr_o,
  output logic [TAG_W-1:0] instr_tag_o,
  output logic             instr_err_o,
  output logic             proto_err_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]    inflightCnt, respCnt;
  logic [CW:0]      creditSum;
  logic             creditOk, reqHs, rvalidOk;
  logic             tagFull, tagEmpty, respFull, respEmpty;
  logic             respPop, headMatch;
  logic [TAG_W-1:0] tagHead;
  resp_entry_t      respIn, respHead;
  logic             protoErr_q, protoErr_d;

  // Credits count both outstanding requests and undelivered responses, so the
  // response FIFO can never overflow.
  assign creditSum = {1'b0, inflightCnt} + {1'b0, respCnt};
  assign creditOk  = creditSum < (CW+1)'(DEPTH);

  assign mem_req_o   = req_en_i && creditOk;
  assign mem_addr_o  = req_addr_i & ~32'h3;
  assign reqHs       = mem_req_o && mem_gnt_i;
  assign req_ready_o = reqHs;

  assign rvalidOk = mem_rvalid_i && !tagEmpty;
  assign respIn   = '{rdata: mem_rdata_i, tag: tagHead, err: mem_err_i};

  imem_fifo #(.WIDTH(TAG_W), .DEPTH(DEPTH)) u_tagFifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (reqHs),
    .data_i  (req_tag_i),
    .pop_i   (rvalidOk),
    .data_o  (tagHead),
    .full_o  (tagFull),
    .empty_o (tagEmpty),
    .count_o (inflightCnt)
  );

  imem_fifo #(.WIDTH($bits(resp_entry_t)), .DEPTH(DEPTH)) u_respFifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (rvalidOk),
    .data_i  (respIn),
    .pop_i   (respPop),
    .data_o  (respHead),
    .full_o  (respFull),
    .empty_o (respEmpty),
    .count_o (respCnt)
  );

  // A mismatching head is discarded even when decode is not ready.
  assign headMatch     = !respEmpty && (respHead.tag == expected_tag_i);
  assign respPop       = !respEmpty && (!headMatch || instr_ready_i);
  assign instr_valid_o = headMatch;
  assign instr_o       = respEmpty ? '0 : respHead.rdata;
  assign instr_tag_o   = respEmpty ? '0 : respHead.tag;
  assign instr_err_o   = respEmpty ? 1'b0 : respHead.err;

  assign protoErr_d  = protoErr_q || (mem_rvalid_i && tagEmpty);
  assign proto_err_o = protoErr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      protoErr_q <= 1'b0;
    end else begin
      protoErr_q <= protoErr_d;
    end
  end

  assert property (@(posedge clk) disable iff (!reset_n) !(rvalidOk && respFull && !respPop));
  assert property (@(posedge clk) disable iff (!reset_n) !(reqHs && tagFull && !rvalidOk));

endmodule

// File: tb/tb_imem_bridge.sv
// Self-checking bench for imem_bridge: a bus responder feeds a response
// scoreboard that is compared against the decode-side outputs every cycle.
module tb_imem_bridge;
  import imem_bridge_pkg::*;

  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  tag;
  } req_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_en_i;
  logic [31:0] req_addr_i;
  logic [2:0]  req_tag_i;
  logic        req_ready_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
  logic [2:0]  expected_tag_i;
  logic        instr_ready_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [2:0]  instr_tag_o;
  logic        instr_err_o;
  logic        proto_err_o;

  req_t        reqQ[$];
  req_t        busQ[$];
  resp_entry_t sb[$];

  int          checks = 0;
  int          fails = 0;
  int          mInflight = 0;
  int          delivered = 0;
  logic        protoExp = 1'b0;
  logic        gnt = 1'b1;
  logic        rspEn = 1'b1;
  logic        forceRv = 1'b0;
  logic        ready = 1'b1;
  logic [2:0]  expTag = '0;
  logic [31:0] errAddr = 32'hFFFF_FFFF;
  logic [31:0] lastData = '0;
  logic [7:0]  errLog = '0;

  imem_bridge #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_en_i       (req_en_i),
    .req_addr_i     (req_addr_i),
    .req_tag_i      (req_tag_i),
    .req_ready_o    (req_ready_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .mem_err_i      (mem_err_i),
    .expected_tag_i (expected_tag_i),
    .instr_ready_i  (instr_ready_i),
    .instr_valid_o  (instr_valid_o),
    .instr_o        (instr_o),
    .instr_tag_o    (instr_tag_o),
    .instr_err_o    (instr_err_o),
    .proto_err_o    (proto_err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // One bus/decode cycle: drive at the falling edge, check mid-cycle, advance the model.
  task automatic applyStimulus();
    req_t        r;
    resp_entry_t e;
    logic        expReq, hs, expValid, rvReal;
    @(negedge clk);
    rvReal = 1'b0;
    e = '0;
    if (reqQ.size() > 0) begin
      req_en_i = 1'b1; req_addr_i = reqQ[0].addr; req_tag_i = reqQ[0].tag;
    end else begin
      req_en_i = 1'b0; req_addr_i = '0; req_tag_i = '0;
    end
    mem_gnt_i = gnt; expected_tag_i = expTag; instr_ready_i = ready;
    if (rspEn && busQ.size() > 0) begin
      r = busQ.pop_front();
      e.rdata = memData(r.addr & ~32'h3); e.tag = r.tag; e.err = ((r.addr & ~32'h3) == errAddr);
      mem_rvalid_i = 1'b1; mem_rdata_i = e.rdata; mem_err_i = e.err; rvReal = 1'b1;
    end else if (forceRv) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0; mem_err_i = 1'b0; forceRv = 1'b0;
    end else begin
      mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    end
    #1;
    expReq = req_en_i && ((mInflight + sb.size()) < DEPTH);
    hs = expReq && gnt;
    checks++;
    if (mem_req_o !== expReq) begin
      fails++; $display("[TB] FAIL mem_req: got %b want %b", mem_req_o, expReq);
    end
    if (expReq) begin
      checks++;
      if (mem_addr_o !== (reqQ[0].addr & ~32'h3)) begin
        fails++; $display("[TB] FAIL mem_addr: got %h want %h", mem_addr_o, reqQ[0].addr & ~32'h3);
      end
    end
    checks++;
    if (req_ready_o !== hs) begin
      fails++; $display("[TB] FAIL req_ready: got %b want %b", req_ready_o, hs);
    end
    expValid = (sb.size() > 0) && (sb[0].tag == expTag);
    checks++;
    if (instr_valid_o !== expValid) begin
      fails++; $display("[TB] FAIL instr_valid: got %b want %b", instr_valid_o, expValid);
    end
    checks++;
    if (sb.size() > 0) begin
      if ({instr_o, instr_tag_o, instr_err_o} !== {sb[0].rdata, sb[0].tag, sb[0].err}) begin
        fails++;
        $display("[TB] FAIL head: got %h/%0d/%b want %h/%0d/%b", instr_o, instr_tag_o, instr_err_o, sb[0].rdata, sb[0].tag, sb[0].err);
      end
    end else if ({instr_o, instr_tag_o, instr_err_o} !== '0) begin
      fails++; $display("[TB] FAIL empty_head: got %h/%0d/%b want 0", instr_o, instr_tag_o, instr_err_o);
    end
    checks++;
    if (proto_err_o !== protoExp) begin
      fails++; $display("[TB] FAIL proto_err: got %b want %b", proto_err_o, protoExp);
    end
    if (instr_valid_o && ready) begin
      delivered++; lastData = instr_o; errLog = {errLog[6:0], instr_err_o};
    end
    if (sb.size() > 0 && (!expValid || ready)) void'(sb.pop_front());
    if (mem_rvalid_i && mInflight == 0) protoExp = 1'b1;
    if (hs) begin
      busQ.push_back(reqQ.pop_front()); mInflight++;
    end
    if (rvReal) begin
      sb.push_back(e); mInflight--;
    end
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((reqQ.size() > 0 || mInflight > 0 || sb.size() > 0) && n < limit) begin
      applyStimulus();
      n++;
    end
    checks++;
    if (reqQ.size() > 0 || mInflight > 0 || sb.size() > 0) begin
      fails++; $display("[TB] FAIL drain_timeout: got %0d outstanding want 0", reqQ.size() + mInflight + sb.size());
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset_n = 1'b0;
    req_en_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    reqQ.delete(); busQ.delete(); sb.delete(); mInflight = 0; protoExp = 1'b0;
    #1;
    checks++;
    if ({instr_valid_o, instr_o, instr_tag_o, instr_err_o, proto_err_o} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got v=%b i=%h t=%0d e=%b p=%b want all 0", instr_valid_o, instr_o, instr_tag_o, instr_err_o, proto_err_o);
    end
    req_en_i = 1'b1;
    #1;
    checks++;
    if (mem_req_o !== 1'b1) begin
      fails++; $display("[TB] FAIL reset_mem_req: got %b want 1", mem_req_o);
    end
    req_en_i = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_en_i = 1'b0; req_addr_i = '0; req_tag_i = '0; mem_gnt_i = 1'b1;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0; expected_tag_i = '0; instr_ready_i = 1'b1;
    applyReset();
  endtask

  task automatic test_zero_wait();
    delivered = 0; expTag = 3'd0; ready = 1'b1; rspEn = 1'b1; gnt = 1'b1;
    for (int i = 0; i < 4; i++) reqQ.push_back('{addr: 32'(i * 4), tag: 3'd0});
    applyStimulus();
    checks++;
    if (instr_valid_o !== 1'b0) begin
      fails++; $display("[TB] FAIL zw_cycle0: got %b want 0", instr_valid_o);
    end
    applyStimulus();
    checks++;
    if (instr_valid_o !== 1'b0) begin
      fails++; $display("[TB] FAIL zw_cycle1: got %b want 0", instr_valid_o);
    end
    applyStimulus();
    checks++;
    if (instr_valid_o !== 1'b1 || instr_o !== memData(32'h0)) begin
      fails++; $display("[TB] FAIL zw_cycle2: got %b/%h want 1/%h", instr_valid_o, instr_o, memData(32'h0));
    end
    drain(30);
    checks++;
    if (delivered !== 4 || lastData !== memData(32'hC)) begin
      fails++; $display("[TB] FAIL zw_delivered: got %0d/%h want 4/%h", delivered, lastData, memData(32'hC));
    end
  endtask

  task automatic test_backpressure();
    delivered = 0; ready = 1'b0;
    for (int i = 0; i < 4; i++) reqQ.push_back('{addr: 32'h40 + 32'(i * 4), tag: 3'd0});
    for (int i = 0; i < 3; i++) applyStimulus();
    checks++;
    if (mem_req_o !== 1'b0 || req_ready_o !== 1'b0) begin
      fails++; $display("[TB] FAIL bp_stall: got req=%b rdy=%b want 0/0", mem_req_o, req_ready_o);
    end
    applyStimulus();
    ready = 1'b1;
    drain(40);
    checks++;
    if (delivered !== 4 || lastData !== memData(32'h4C)) begin
      fails++; $display("[TB] FAIL bp_delivered: got %0d/%h want 4/%h", delivered, lastData, memData(32'h4C));
    end
  endtask

  task automatic test_tag_flush();
    expTag = 3'd1; rspEn = 1'b0; ready = 1'b1;
    reqQ.push_back('{addr: 32'h80, tag: 3'd1});
    reqQ.push_back('{addr: 32'h84, tag: 3'd1});
    applyStimulus();
    applyStimulus();
    delivered = 0; expTag = 3'd2; rspEn = 1'b1;
    reqQ.push_back('{addr: 32'h102, tag: 3'd2});
    drain(40);
    checks++;
    if (delivered !== 1 || lastData !== memData(32'h100)) begin
      fails++; $display("[TB] FAIL flush_delivered: got %0d/%h want 1/%h", delivered, lastData, memData(32'h100));
    end
  endtask

  task automatic test_error();
    delivered = 0; errLog = '0; expTag = 3'd0; errAddr = 32'h4;
    reqQ.push_back('{addr: 32'h0, tag: 3'd0});
    reqQ.push_back('{addr: 32'h4, tag: 3'd0});
    drain(30);
    checks++;
    if (delivered !== 2 || errLog[1:0] !== 2'b01 || lastData !== memData(32'h4)) begin
      fails++; $display("[TB] FAIL err_bits: got %0d/%b/%h want 2/01/%h", delivered, errLog[1:0], lastData, memData(32'h4));
    end
    errAddr = 32'hFFFF_FFFF;
  endtask

  task automatic test_proto();
    forceRv = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus();
    checks++;
    if (proto_err_o !== 1'b1 || instr_valid_o !== 1'b0) begin
      fails++; $display("[TB] FAIL proto_hold: got p=%b v=%b want 1/0", proto_err_o, instr_valid_o);
    end
    applyReset();
    #1;
    checks++;
    if (proto_err_o !== 1'b0) begin
      fails++; $display("[TB] FAIL proto_clear: got %b want 0", proto_err_o);
    end
  endtask

  task automatic test_reset_midflight();
    rspEn = 1'b0; expTag = 3'd0; ready = 1'b1;
    reqQ.push_back('{addr: 32'h300, tag: 3'd0});
    reqQ.push_back('{addr: 32'h304, tag: 3'd0});
    applyStimulus();
    applyStimulus();
    applyReset();
    rspEn = 1'b1; delivered = 0;
    reqQ.push_back('{addr: 32'h200, tag: 3'd0});
    drain(20);
    checks++;
    if (delivered !== 1 || lastData !== memData(32'h200) || proto_err_o !== 1'b0) begin
      fails++; $display("[TB] FAIL post_reset: got %0d/%h/%b want 1/%h/0", delivered, lastData, proto_err_o, memData(32'h200));
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_tag_flush();
    test_error();
    test_proto();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
